// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator.
// A clock divider produces one pixel tick every CLK_DIV clocks. On each tick
// edge the display position (oCol, oRow) and a fetch position that leads it by
// LOOKAHEAD ticks both advance through the H_TOTAL x V_TOTAL raster. All
// outputs are registered and derived from the next-state counters, so they
// change on the same edge as the counters.
//
// Ports:
//   Clock                      system clock
//   Reset                      asynchronous active-high reset
//   iEnable                    run; low loads the reset state on the next edge
//   iRgb[11:0]                 {R,G,B} for the position fetched LOOKAHEAD ticks earlier
//   oVgaRed/Green/Blue[3:0]    registered colour, zero outside the visible area
//   oVgaHsync / oVgaVsync      sync pulses, active level H_POL / V_POL
//   oActive                    display position inside the visible area
//   oPixelTick                 one-clock strobe per pixel
//   oCol / oRow [CW-1:0]       display position
//   oFetch                     fetch position inside the visible area
//   oFetchCol / oFetchRow      fetch position
//   oLineStart / oFrameStart   one-clock pulses entering column 0 / position (0,0)
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int H_POL     = 0,
   parameter int V_POL     = 0,
   parameter int CLK_DIV   = 1,
   parameter int LOOKAHEAD = 2,
   parameter int CW        = 12
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          iEnable,
   input  logic [11:0]   iRgb,
   output logic [3:0]    oVgaRed,
   output logic [3:0]    oVgaGreen,
   output logic [3:0]    oVgaBlue,
   output logic          oVgaHsync,
   output logic          oVgaVsync,
   output logic          oActive,
   output logic          oPixelTick,
   output logic [CW-1:0] oCol,
   output logic [CW-1:0] oRow,
   output logic          oFetch,
   output logic [CW-1:0] oFetchCol,
   output logic [CW-1:0] oFetchRow,
   output logic          oLineStart,
   output logic          oFrameStart
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE = DW'(1);
   localparam logic [CW-1:0] CW_ONE  = CW'(1);
   localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS   = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_VIS   = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [CW-1:0] FCOL_RST = CW'(LOOKAHEAD);
   localparam logic HS_ON = (H_POL != 0) ? 1'b1 : 1'b0;
   localparam logic VS_ON = (V_POL != 0) ? 1'b1 : 1'b0;

   // Raster counter step with wrap at the last position.
   function automatic logic [CW-1:0] step(input logic [CW-1:0] v, input logic [CW-1:0] last);
      logic [CW-1:0] r;
      if (v == last) begin
         r = '0;
      end else begin
         r = v + CW_ONE;
      end
      return r;
   endfunction

   // Inclusive range test used for both sync windows.
   function automatic logic in_span(input logic [CW-1:0] v, input logic [CW-1:0] first,
                                    input logic [CW-1:0] last);
      return (v >= first) && (v <= last);
   endfunction

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] col_q, col_d, row_q, row_d;
   logic [CW-1:0] fcol_q, fcol_d, frow_q, frow_d;
   logic [11:0]   rgb_q, rgb_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d;
   logic          active_q, active_d, fetch_q, fetch_d;
   logic          tick_q, tick_d;
   logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic          tick_edge;

   // Next-state counters and the registered outputs derived from them.
   always_comb begin
      tick_edge     = (div_q == DIV_MAX);
      div_d         = div_q;
      col_d         = col_q;
      row_d         = row_q;
      fcol_d        = fcol_q;
      frow_d        = frow_q;
      rgb_d         = rgb_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      active_d      = active_q;
      fetch_d       = fetch_q;
      tick_d        = tick_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (!iEnable) begin
         // Synchronous restart: same values as the asynchronous reset.
         div_d    = '0;
         col_d    = '0;
         row_d    = '0;
         fcol_d   = FCOL_RST;
         frow_d   = '0;
         rgb_d    = 12'h000;
         hsync_d  = ~HS_ON;
         vsync_d  = ~VS_ON;
         active_d = 1'b1;
         fetch_d  = 1'b1;
         tick_d   = 1'b0;
      end else begin
         if (tick_edge) begin
            div_d  = '0;
            col_d  = step(col_q, H_LAST);
            fcol_d = step(fcol_q, H_LAST);
            if (col_q == H_LAST) begin
               row_d = step(row_q, V_LAST);
            end else begin
               row_d = row_q;
            end
            if (fcol_q == H_LAST) begin
               frow_d = step(frow_q, V_LAST);
            end else begin
               frow_d = frow_q;
            end
         end else begin
            div_d = div_q + DIV_ONE;
         end
         active_d = (col_d < H_VIS) && (row_d < V_VIS);
         fetch_d  = (fcol_d < H_VIS) && (frow_d < V_VIS);
         hsync_d  = in_span(col_d, HS_FIRST, HS_LAST) ? HS_ON : ~HS_ON;
         vsync_d  = in_span(row_d, VS_FIRST, VS_LAST) ? VS_ON : ~VS_ON;
         tick_d   = (div_d == DIV_MAX);
         // Strobes only on a real tick edge, so a restart into (0,0) stays quiet.
         line_start_d  = tick_edge && (col_d == '0);
         frame_start_d = tick_edge && (col_d == '0) && (row_d == '0);
         if (tick_edge) begin
            rgb_d = active_d ? iRgb : 12'h000;
         end else begin
            rgb_d = rgb_q;
         end
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         div_q         <= '0;
         col_q         <= '0;
         row_q         <= '0;
         fcol_q        <= FCOL_RST;
         frow_q        <= '0;
         rgb_q         <= 12'h000;
         hsync_q       <= ~HS_ON;
         vsync_q       <= ~VS_ON;
         active_q      <= 1'b1;
         fetch_q       <= 1'b1;
         tick_q        <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         col_q         <= col_d;
         row_q         <= row_d;
         fcol_q        <= fcol_d;
         frow_q        <= frow_d;
         rgb_q         <= rgb_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         fetch_q       <= fetch_d;
         tick_q        <= tick_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign oVgaRed     = rgb_q[11:8];
   assign oVgaGreen   = rgb_q[7:4];
   assign oVgaBlue    = rgb_q[3:0];
   assign oVgaHsync   = hsync_q;
   assign oVgaVsync   = vsync_q;
   assign oActive     = active_q;
   assign oPixelTick  = tick_q;
   assign oCol        = col_q;
   assign oRow        = row_q;
   assign oFetch      = fetch_q;
   assign oFetchCol   = fcol_q;
   assign oFetchRow   = frow_q;
   assign oLineStart  = line_start_q;
   assign oFrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Randomised scoreboard bench for vga_timing_gen using a reduced raster so
// several full frames fit in a short run. The reference model counts clocks
// and pixel ticks since the last restart and derives every position from that
// tick count with division and modulo over the raster size.
module tb_vga_timing_gen;

   localparam int H_ACTIVE  = 8;
   localparam int H_FP      = 2;
   localparam int H_SYNC    = 3;
   localparam int H_BP      = 2;
   localparam int V_ACTIVE  = 4;
   localparam int V_FP      = 1;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 2;
   localparam int H_POL     = 1;
   localparam int V_POL     = 0;
   localparam int CLK_DIV   = 3;
   localparam int LOOKAHEAD = 2;
   localparam int CW        = 12;

   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME      = H_TOTAL * V_TOTAL;
   localparam int FRAME_CLKS = FRAME * CLK_DIV;
   localparam logic HS_ON = (H_POL != 0) ? 1'b1 : 1'b0;
   localparam logic VS_ON = (V_POL != 0) ? 1'b1 : 1'b0;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          iEnable;
   logic [11:0]   iRgb;
   logic [3:0]    oVgaRed, oVgaGreen, oVgaBlue;
   logic          oVgaHsync, oVgaVsync, oActive, oPixelTick;
   logic [CW-1:0] oCol, oRow, oFetchCol, oFetchRow;
   logic          oFetch, oLineStart, oFrameStart;

   always #5 Clock = ~Clock;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .H_POL(H_POL), .V_POL(V_POL), .CLK_DIV(CLK_DIV),
      .LOOKAHEAD(LOOKAHEAD), .CW(CW)
   ) dut (
      .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iRgb(iRgb),
      .oVgaRed(oVgaRed), .oVgaGreen(oVgaGreen), .oVgaBlue(oVgaBlue),
      .oVgaHsync(oVgaHsync), .oVgaVsync(oVgaVsync), .oActive(oActive),
      .oPixelTick(oPixelTick), .oCol(oCol), .oRow(oRow), .oFetch(oFetch),
      .oFetchCol(oFetchCol), .oFetchRow(oFetchRow),
      .oLineStart(oLineStart), .oFrameStart(oFrameStart)
   );

   typedef struct {
      logic [11:0] rgb;
      logic        hs, vs, act, tick, fetch, ls, fs;
      int          col, row, fcol, frow;
   } exp_t;

   exp_t sb[$];
   exp_t m;
   exp_t mon_e;
   int   m_clk;
   int   m_t;
   logic cur_rst, cur_en;
   logic [11:0] cur_rgb;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   running = 1'b0;
   bit   steady  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         if (n_fail <= 25)
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, req, $time);
      end
   endtask

   // Position-derived fields from the tick count since restart.
   task automatic set_pos();
      int pos, fpos;
      pos    = m_t % FRAME;
      fpos   = (m_t + LOOKAHEAD) % FRAME;
      m.col  = pos % H_TOTAL;
      m.row  = pos / H_TOTAL;
      m.fcol = fpos % H_TOTAL;
      m.frow = fpos / H_TOTAL;
      m.act  = (m.col < H_ACTIVE) && (m.row < V_ACTIVE);
      m.fetch = (m.fcol < H_ACTIVE) && (m.frow < V_ACTIVE);
      m.hs = (m.col >= H_ACTIVE + H_FP && m.col < H_ACTIVE + H_FP + H_SYNC) ? HS_ON : ~HS_ON;
      m.vs = (m.row >= V_ACTIVE + V_FP && m.row < V_ACTIVE + V_FP + V_SYNC) ? VS_ON : ~VS_ON;
   endtask

   task automatic model_reset();
      m_clk = 0;
      m_t   = 0;
      set_pos();
      m.tick = 1'b0;
      m.ls   = 1'b0;
      m.fs   = 1'b0;
      m.rgb  = 12'h000;
   endtask

   // One clock edge with the inputs that were held across it.
   task automatic model_edge();
      bit te;
      if (cur_rst || !cur_en) begin
         model_reset();
      end else begin
         te = ((m_clk % CLK_DIV) == CLK_DIV - 1);
         m_clk++;
         if (te) m_t++;
         set_pos();
         m.tick = ((m_clk % CLK_DIV) == CLK_DIV - 1);
         m.ls   = te && (m.col == 0);
         m.fs   = te && (m.col == 0) && (m.row == 0);
         if (te) m.rgb = m.act ? cur_rgb : 12'h000;
      end
   endtask

   task automatic cycle(input logic r, input logic e, input logic [11:0] rgb);
      @(posedge Clock);
      model_edge();
      #1;
      Reset   = r;
      iEnable = e;
      iRgb    = rgb;
      cur_rst = r;
      cur_en  = e;
      cur_rgb = rgb;
      if (r) model_reset();
      sb.push_back(m);
      running = 1'b1;
   endtask

   // Monitor: pops one expectation per clock and checks timing properties.
   int  clk_cnt   = 0;
   int  last_fs   = -1;
   int  hs_cnt    = 0;
   bit  have_line = 1'b0;
   int  vs_lines  = 0;
   bit  have_frame = 1'b0;
   initial begin
      forever begin
         @(negedge Clock);
         if (running) begin
            clk_cnt++;
            if (sb.size() == 0) begin
               chk("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
               mon_e = sb.pop_front();
               chk("rgb",        {20'd0, oVgaRed, oVgaGreen, oVgaBlue}, {20'd0, mon_e.rgb});
               chk("hsync",      {31'd0, oVgaHsync},   {31'd0, mon_e.hs});
               chk("vsync",      {31'd0, oVgaVsync},   {31'd0, mon_e.vs});
               chk("active",     {31'd0, oActive},     {31'd0, mon_e.act});
               chk("pixel_tick", {31'd0, oPixelTick},  {31'd0, mon_e.tick});
               chk("col",        32'(oCol),            32'(mon_e.col));
               chk("row",        32'(oRow),            32'(mon_e.row));
               chk("fetch",      {31'd0, oFetch},      {31'd0, mon_e.fetch});
               chk("fetch_col",  32'(oFetchCol),       32'(mon_e.fcol));
               chk("fetch_row",  32'(oFetchRow),       32'(mon_e.frow));
               chk("line_start", {31'd0, oLineStart},  {31'd0, mon_e.ls});
               chk("frame_start",{31'd0, oFrameStart}, {31'd0, mon_e.fs});
            end
            if (steady) begin
               if (oLineStart) begin
                  if (have_line) chk("hsync_width_clks", 32'(hs_cnt), 32'(H_SYNC * CLK_DIV));
                  have_line = 1'b1;
                  hs_cnt = 0;
                  if (oFrameStart) begin
                     if (have_frame) chk("vsync_lines", 32'(vs_lines), 32'(V_SYNC));
                     if (last_fs >= 0) chk("frame_period_clks", 32'(clk_cnt - last_fs), 32'(FRAME_CLKS));
                     have_frame = 1'b1;
                     last_fs = clk_cnt;
                     vs_lines = 0;
                  end
                  if (oVgaVsync == VS_ON) vs_lines++;
               end
               if (oVgaHsync == HS_ON) hs_cnt++;
            end else begin
               have_line  = 1'b0;
               have_frame = 1'b0;
               last_fs    = -1;
               hs_cnt     = 0;
               vs_lines   = 0;
            end
         end
      end
   end

   initial begin
      int k;
      Reset   = 1'b1;
      iEnable = 1'b0;
      iRgb    = 12'h000;
      cur_rst = 1'b1;
      cur_en  = 1'b0;
      cur_rgb = 12'h000;
      model_reset();
      repeat (3) cycle(1'b1, 1'b0, 12'h000);
      cycle(1'b0, 1'b1, 12'hABC);
      steady = 1'b1;
      // Constant colour for one frame, then random colours, no disruption.
      repeat (FRAME_CLKS) cycle(1'b0, 1'b1, 12'hABC);
      repeat (2 * FRAME_CLKS + 20) cycle(1'b0, 1'b1, 12'($urandom));
      steady = 1'b0;

      // Enable drop mid-line.
      for (k = 0; k < 2 * FRAME_CLKS && !(m.col == 5 && m.row == 1); k++)
         cycle(1'b0, 1'b1, 12'($urandom));
      chk("reach_col5_row1", {31'd0, (m.col == 5 && m.row == 1)}, 32'd1);
      repeat (3) cycle(1'b0, 1'b0, 12'($urandom));
      repeat (60) cycle(1'b0, 1'b1, 12'($urandom));

      // Reset pulse while vertical sync is active.
      for (k = 0; k < 2 * FRAME_CLKS && !(m.row == V_ACTIVE + V_FP && m.col == 3); k++)
         cycle(1'b0, 1'b1, 12'($urandom));
      chk("reach_vsync_row", {31'd0, (m.row == V_ACTIVE + V_FP && m.col == 3)}, 32'd1);
      cycle(1'b1, 1'b1, 12'($urandom));
      cycle(1'b1, 1'b1, 12'($urandom));
      repeat (60) cycle(1'b0, 1'b1, 12'($urandom));

      // Random enables, resets and colours.
      repeat (3000) cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0,
                          12'($urandom));
      cycle(1'b0, 1'b1, 12'h000);
      @(negedge Clock);
      #1;
      running = 1'b0;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the fixed-mode VGA controller.
- Timings, sync polarities, pixel-clock divide and fetch lookahead are all parameters.
- Produces exactly-sized sync pulses, blanking-gated RGB output, line/frame strobes and a lookahead fetch address for the frame-buffer reader.
- Sits between the system clock domain (single clock) and the LogicStart VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixel ticks)
H_SYNC, 96, horizontal sync width (pixel ticks)
H_BP, 48, horizontal back porch (pixel ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, HSync active level (0 = active-low)
V_POL, 0, VSync active level
CLK_DIV, 1, Clock cycles per pixel tick (1..16)
LOOKAHEAD, 2, pixel ticks by which fetch position leads display position (1..H_ACTIVE-1)
CW, 12, counter/coordinate width

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
iEnable  in  1  run; low = synchronous restart to reset state
iRgb  in  12  pixel colour {R,G,B} for the position fetched LOOKAHEAD ticks earlier
oVgaRed/oVgaGreen/oVgaBlue  out  4 each  registered colour, 0 outside active area
oVgaHsync  out  1  horizontal sync, polarity H_POL
oVgaVsync  out  1  vertical sync, polarity V_POL
oActive  out  1  current position inside visible area
oPixelTick  out  1  one-Clock strobe per pixel
oCol, oRow  out  CW each  current display position
oFetch  out  1  fetch position inside visible area
oFetchCol, oFetchRow  out  CW each  fetch position
oLineStart  out  1  one-Clock pulse when oCol becomes 0
oFrameStart  out  1  one-Clock pulse when (oCol,oRow) becomes (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise for the vertical parameters.
- Reset (async):
  - Divider, oCol and oRow = 0.
  - Fetch counters = (LOOKAHEAD, 0).
  - RGB = 0; oPixelTick, oLineStart and oFrameStart = 0.
  - Syncs at inactive level.
  - oActive = 1; oFetch = 1.
- Divider:
  - Counts 0..CLK_DIV-1; oPixelTick high in the Clock where the divider equals CLK_DIV-1.
  - CLK_DIV = 1 gives oPixelTick constantly high.
- On each tick edge:
  - Col advances; at H_TOTAL-1 it wraps to 0 and Row advances.
  - Row wraps at V_TOTAL-1 to 0.
  - Fetch counters follow the same rules, so they lead by exactly LOOKAHEAD ticks across line and frame wraps.
- All outputs are registered and computed from next-state counters, so they change on the same edge as the counters (zero added latency).
- HSync is active for Col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], exactly H_SYNC ticks.
- VSync is active for Row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], exactly V_SYNC lines.
- oActive = Col < H_ACTIVE && Row < V_ACTIVE. oFetch uses the same rule on the fetch counters.
- RGB update on the tick edge: {R,G,B} <= next oActive ? iRgb : 0. Colour is never driven during blanking.
- Strobes:
  - oLineStart and oFrameStart are one Clock wide, on the tick edge entering Col = 0 (resp. Col = 0 and Row = 0).
  - They do not fire on reset exit.
- iEnable low: next edge performs the reset-state load (synchronous); held low keeps that state.
- iEnable rising: counting resumes, and the first tick occurs CLK_DIV Clocks later.
- Reset asserted mid-frame: immediate return to reset state, with no partial sync pulse extension.

Test Plan:
1. Defaults, CLK_DIV=1, run 2 frames.
   - HSync low exactly at ticks 656..751 of each line (96 ticks).
   - VSync low on lines 490..491.
   - oFrameStart period 420000 Clocks.
2. iRgb=12'hABC constant.
   - RGB = A,B,C only while Col<640 and Row<480.
   - RGB = 0 at Col 640..799 and on lines 480..524.
3. LOOKAHEAD=2.
   - At Col=798, Row=10: oFetchCol=0, oFetchRow=11.
   - At Col=799, Row=524: fetch = (1,0).
   - oFetch rises 2 ticks before oActive on every line.
4. CLK_DIV=4, H_ACTIVE=4, all porches and syncs 1, V likewise.
   - oPixelTick every 4th Clock; H_TOTAL=7, so the line takes 28 Clocks.
   - HSync active for 4 Clocks.
5. H_POL=1, V_POL=1: sync outputs inverted relative to scenario 1; timing identical.
6. Mid-line: deassert iEnable for 3 Clocks at Col=300, then reassert; separately pulse Reset at Row=490.
   - Both cases: Col=Row=0, syncs inactive and RGB=0 immediately.
   - No oFrameStart pulse on restart.
